mode1_max_acc: RTL
==================

# mode1_max_acc

Running-max accumulator and feedback controller for the mode-1 max stage of the softmax datapath. It consumes the combinational 4+1-input max-tree result once per accepted beat and holds the running maximum in a register. It feeds that register back as the tree's external input and releases the final vector maximum to the downstream subtract/exponent stage over a valid/ready handshake.

## Interface
- DATAWIDTH, 16, floating-point word width (half precision)
- EXPONENT, 5, exponent field width
- MANTISSA, 10, mantissa field width
- CNT_W, 8, beat counter width
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  tree_max carries a valid beat
- in_last  input  1  qualifies in_valid: final beat of the vector
- in_ready  output  1  block accepts a beat this cycle
- tree_max  input  DATAWIDTH  combinational max-tree result, already compared against ex_max
- ex_max  output  DATAWIDTH  feedback to the tree's external compare input
- out_valid  output  1  max_out holds the final vector maximum
- out_ready  input  1  downstream accepts max_out
- max_out  output  DATAWIDTH  final vector maximum
- beat_cnt  output  CNT_W  beats accepted in the current or just-finished vector
- cnt_ovf  output  1  sticky: the vector exceeded 2^CNT_W-1 beats
- nan_seen  output  1  sticky per vector: a NaN beat was accepted

## Operation
- A beat is accepted when in_valid && in_ready.
- FSM states: IDLE, ACCUM, DONE.
- In IDLE:
  - in_ready=1, ex_max=NEG_INF (16'hFC00).
  - An accepted beat loads max_reg<=tree_max and beat_cnt<=1, and clears cnt_ovf and nan_seen.
  - If in_last is set, go to DONE; otherwise go to ACCUM.
- In ACCUM:
  - in_ready=1, ex_max=max_reg.
  - Each accepted beat loads max_reg<=tree_max. The tree has already folded in max_reg, so no compare is done here.
  - beat_cnt increments and saturates at 2^CNT_W-1. An accept while beat_cnt is saturated sets cnt_ovf.
  - An accept with in_last set goes to DONE.
- In DONE:
  - in_ready=0, out_valid=1, max_out=max_reg, ex_max=NEG_INF.
  - out_ready=1 returns the FSM to IDLE.
  - beat_cnt, cnt_ovf and nan_seen hold their values until the next first beat.
- in_last is ignored when in_valid=0.
- max_out holds max_reg in all states. It is meaningful only while out_valid=1.
- A single-beat vector (in_last on the first beat) is legal and goes IDLE->DONE directly.

## Timing
- Reset values: state=IDLE, max_reg=16'hFC00, max_out=16'hFC00, ex_max=16'hFC00, in_ready=1, out_valid=0, beat_cnt=0, cnt_ovf=0, nan_seen=0.
- Reset asserted mid-vector aborts the vector immediately. No partial result is emitted.
- Latency: out_valid rises on the clock edge that accepts the in_last beat, i.e. max_out is visible in the next cycle.
- Throughput: one beat per cycle in IDLE/ACCUM.
- One bubble cycle separates vectors: IDLE follows the DONE handshake, and in_ready stays 0 throughout DONE.
- ex_max, in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid/out_ready to any output.
- out_valid stays high and max_out stays stable until out_ready=1 (no drop under backpressure).

## Configuration
- MODE1_MAX_NAN_CHECK_EN defined:
  - A beat whose tree_max has exponent all ones and nonzero mantissa sets nan_seen.
  - While nan_seen=1, max_out reads canonical NaN 16'h7E00 instead of max_reg.
  - ex_max still feeds back max_reg.
- MODE1_MAX_NAN_CHECK_EN undefined:
  - nan_seen is tied to 0.
  - max_out is always max_reg.
  - No NaN decode logic is synthesized.

## Test plan
- Reset then 3 beats tree_max=3C00, 4000, 4200, last on the third -> ex_max sequence FC00, 3C00, 4000; then out_valid=1, max_out=4200, beat_cnt=3.
- Single beat C000 with in_last, out_ready held 0 for 5 cycles -> out_valid held, max_out=C000, in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
- Two back-to-back vectors (2 beats, then 1 beat) -> second vector starts with ex_max=FC00 and beat_cnt restarts at 1; exactly one bubble cycle between the vectors.
- CNT_W=2, 4-beat vector -> beat_cnt saturates at 3, cnt_ovf=1 at DONE, max still correct.
- reset_n pulsed low during ACCUM after 2 beats -> all outputs at reset values immediately; no out_valid pulse.
- With MODE1_MAX_NAN_CHECK_EN, beats 3C00, 7E01, last 4000 -> nan_seen=1, max_out=7E00. Without the macro, the same stimulus gives nan_seen=0 and max_out=max_reg.

Source files
------------

// File: rtl/mode1_max_acc.sv
// Running-max register and feedback controller for the mode-1 softmax max stage.
// Optional NaN tracking is compiled in when MODE1_MAX_NAN_CHECK_EN is defined.
module mode1_max_acc #(
  parameter int DATAWIDTH = 16,
  parameter int EXPONENT  = 5,
  parameter int MANTISSA  = 10,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] tree_max,
  output logic [DATAWIDTH-1:0] ex_max,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] max_out,
  output logic [CNT_W-1:0]     beat_cnt,
  output logic                 cnt_ovf,
  output logic                 nan_seen
);

  localparam logic [DATAWIDTH-1:0] NEG_INF = {1'b1, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [DATAWIDTH-1:0]   r_max_reg;
  logic [CNT_W-1:0]       r_beat_cnt;
  logic                   r_cnt_ovf;
  logic                   w_accept;

  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b1;
    out_valid    = 1'b0;
    ex_max       = NEG_INF;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = in_last ? DONE : ACCUM;
      end
      ACCUM: begin
        ex_max = r_max_reg;
        if (w_accept && in_last) w_state_next = DONE;
      end
      DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // The tree already compared against ex_max, so the accepted beat is the new max.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_max_reg  <= NEG_INF;
      r_beat_cnt <= '0;
      r_cnt_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_max_reg <= tree_max;
      if (r_state == IDLE) begin
        r_beat_cnt <= CNT_W'(1);
        r_cnt_ovf  <= 1'b0;
      end else if (r_beat_cnt == '1) begin
        r_cnt_ovf <= 1'b1;
      end else begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
    end
  end

  assign beat_cnt = r_beat_cnt;
  assign cnt_ovf  = r_cnt_ovf;

`ifdef MODE1_MAX_NAN_CHECK_EN
  localparam logic [DATAWIDTH-1:0] CANON_NAN =
    {1'b0, {EXPONENT{1'b1}}, 1'b1, {(MANTISSA-1){1'b0}}};

  logic r_nan_seen;
  logic w_is_nan;

  assign w_is_nan = (&tree_max[DATAWIDTH-2 -: EXPONENT]) && (|tree_max[MANTISSA-1:0]);

  // First beat of a vector restarts the flag; later beats only OR in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         r_nan_seen <= 1'b0;
    else if (w_accept && r_state == IDLE) r_nan_seen <= w_is_nan;
    else if (w_accept)                    r_nan_seen <= r_nan_seen | w_is_nan;
  end

  assign nan_seen = r_nan_seen;
  assign max_out  = r_nan_seen ? CANON_NAN : r_max_reg;
`else
  assign nan_seen = 1'b0;
  assign max_out  = r_max_reg;
`endif

endmodule
